// File: rtl/instr_encoder_pkg.sv
// Shared RV32I encoding constants: format codes, major opcodes and encoder FSM states.
// Keeps the encoder and decoder in agreement on bit-level encodings.
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    FmtR = 3'd0,
    FmtI = 3'd1,
    FmtS = 3'd2,
    FmtB = 3'd3,
    FmtJ = 3'd4
  } fmt_e;

  localparam logic [6:0] OpR = 7'b0110011;
  localparam logic [6:0] OpI = 7'b0010011;
  localparam logic [6:0] OpS = 7'b0100011;
  localparam logic [6:0] OpB = 7'b1100011;
  localparam logic [6:0] OpJ = 7'b1101111;

  localparam logic [31:0] InstrNop = 32'h0000_0013;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDrain
  } state_e;

  // True when v, read as a signed value, is representable in 'bits' two's-complement bits.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    int lim;
    lim = 1 << (bits - 1);
    return ($signed(v) >= -lim) && ($signed(v) < lim);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer: fmt + fields -> 32-bit word, illegal-fmt and range flags.
// Optional immediate checking is enabled by defining INSTR_ENC_RANGE_CHECK_EN.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [2:0]  i_fmt,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_illegal,
  output logic        o_range_err
);

  always_comb begin
    o_word    = InstrNop;
    o_illegal = 1'b0;
    case (i_fmt)
      FmtR: o_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, OpR};
      FmtI: o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, OpI};
      FmtS: o_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], OpS};
      FmtB: o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3, i_imm[4:1], i_imm[11], OpB};
      FmtJ: o_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OpJ};
      default: o_illegal = 1'b1;
    endcase
  end

`ifdef INSTR_ENC_RANGE_CHECK_EN
  always_comb begin
    o_range_err = 1'b0;
    case (i_fmt)
      FmtI, FmtS: o_range_err = !fits_signed(i_imm, 12);
      FmtB:       o_range_err = !fits_signed(i_imm, 13) || i_imm[0];
      FmtJ:       o_range_err = !fits_signed(i_imm, 21) || i_imm[0];
      default:    o_range_err = 1'b0;
    endcase
  end
`else
  logic w_unused_imm_hi;
  assign w_unused_imm_hi = ^i_imm[31:21];
  assign o_range_err     = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder / imem loader: fields in over valid/ready, packed words out to imem.
// Immediate range checking (err[1]) exists only when INSTR_ENC_RANGE_CHECK_EN is defined.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic              i_in_last,
  input  logic [2:0]        i_in_fmt,
  input  logic [2:0]        i_in_funct3,
  input  logic [6:0]        i_in_funct7,
  input  logic [4:0]        i_in_rd,
  input  logic [4:0]        i_in_rs1,
  input  logic [4:0]        i_in_rs2,
  input  logic [31:0]       i_in_imm,
  output logic              o_imem_we,
  input  logic              i_imem_ready,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic [CNT_W-1:0]  o_words,
  output logic [1:0]        o_err
);

  state_e            r_state;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [CNT_W-1:0]  r_words;
  logic [1:0]        r_err;
  logic              r_done;

  logic [31:0] w_word;
  logic        w_illegal;
  logic        w_range;
  logic        w_in_acc;
  logic        w_wr_acc;
  logic        w_unused_base;

  assign w_unused_base = ^i_base_addr[1:0];

  instr_pack u_pack (
    .i_fmt       (i_in_fmt),
    .i_funct3    (i_in_funct3),
    .i_funct7    (i_in_funct7),
    .i_rd        (i_in_rd),
    .i_rs1       (i_in_rs1),
    .i_rs2       (i_in_rs2),
    .i_imm       (i_in_imm),
    .o_word      (w_word),
    .o_illegal   (w_illegal),
    .o_range_err (w_range)
  );

  // A new field may enter in the same cycle the held word drains, so there is no bubble.
  assign o_in_ready = (r_state == StLoad) && (!r_we || i_imem_ready);
  assign w_in_acc   = i_in_valid && o_in_ready;
  assign w_wr_acc   = r_we && i_imem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_words <= '0;
      r_err   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_wr_acc) begin
        r_addr <= r_addr + ADDR_W'(4);
        if (r_words != '1) r_words <= r_words + CNT_W'(1);
      end
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_state <= StLoad;
            r_addr  <= {i_base_addr[ADDR_W-1:2], 2'b00};
            r_words <= '0;
            r_err   <= '0;
          end
        end
        StLoad: begin
          if (w_in_acc) begin
            r_we    <= 1'b1;
            r_wdata <= w_word;
            r_err   <= r_err | {w_range, w_illegal};
            if (i_in_last) r_state <= StDrain;
          end else if (w_wr_acc) begin
            r_we <= 1'b0;
          end
        end
        StDrain: begin
          if (w_wr_acc) begin
            r_we    <= 1'b0;
            r_state <= StIdle;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_imem_we    = r_we;
  assign o_imem_addr  = r_addr;
  assign o_imem_wdata = r_wdata;
  assign o_busy       = (r_state != StIdle);
  assign o_done       = r_done;
  assign o_words      = r_words;
  assign o_err        = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed, table-driven bench for instr_encoder with hand-encoded RV32I words.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_last = 1'b0;
  logic [2:0]  in_fmt = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        imem_we;
  logic        imem_ready = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        busy;
  logic        done;
  logic [15:0] words;
  logic [1:0]  err;

  instr_encoder #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (start),
    .i_base_addr  (base_addr),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_in_last    (in_last),
    .i_in_fmt     (in_fmt),
    .i_in_funct3  (in_funct3),
    .i_in_funct7  (in_funct7),
    .i_in_rd      (in_rd),
    .i_in_rs1     (in_rs1),
    .i_in_rs2     (in_rs2),
    .i_in_imm     (in_imm),
    .o_imem_we    (imem_we),
    .i_imem_ready (imem_ready),
    .o_imem_addr  (imem_addr),
    .o_imem_wdata (imem_wdata),
    .o_busy       (busy),
    .o_done       (done),
    .o_words      (words),
    .o_err        (err)
  );

  always #5 clk = ~clk;

`ifdef INSTR_ENC_RANGE_CHECK_EN
  localparam logic [1:0] RangeErr = 2'b10;
`else
  localparam logic [1:0] RangeErr = 2'b00;
`endif

  typedef struct {
    logic [2:0]  fmt;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] word;
  } vec_t;

  localparam int NVec = 8;
  vec_t tbl [NVec];

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] q_addr [$];
  logic [31:0] q_data [$];

  // Write monitor: records every accepted imem write.
  always @(negedge clk) begin
    if (imem_we && imem_ready) begin
      q_addr.push_back(imem_addr);
      q_data.push_back(imem_wdata);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [31:0] base);
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = base;
    @(posedge clk); #1;
    start     = 1'b0;
    q_addr.delete();
    q_data.delete();
  endtask

  task automatic send(input vec_t v, input logic last);
    bit ok;
    in_fmt    = v.fmt;
    in_funct3 = v.f3;
    in_funct7 = v.f7;
    in_rd     = v.rd;
    in_rs1    = v.rs1;
    in_rs2    = v.rs2;
    in_imm    = v.imm;
    in_last   = last;
    in_valid  = 1'b1;
    ok        = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL send_timeout: got in_ready 0 want 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    tbl[0] = '{3'd0, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0,        32'h002081B3}; // add
    tbl[1] = '{3'd1, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFF00293}; // addi -1
    tbl[2] = '{3'd3, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8,        32'h00208463}; // beq +8
    tbl[3] = '{3'd4, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd8,        32'h0080006F}; // jal x0,+8
    tbl[4] = '{3'd2, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd4,        32'h0020A223}; // sw
    tbl[5] = '{3'd3, 3'd1, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 32'hFE209EE3}; // bne -4
    tbl[6] = '{3'd0, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0,        32'h402081B3}; // sub
    tbl[7] = '{3'd4, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'hFFFFFFF8, 32'hFF9FF0EF}; // jal ra,-8

    // Reset values
    #12;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_words", 32'(words), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;

    // Table: one back-to-back load of every vector
    imem_ready = 1'b1;
    do_start(32'h100);
    check("start_busy", 32'(busy), 32'd1);
    for (int i = 0; i < NVec; i++) send(tbl[i], i == NVec - 1);
    wait_done("tbl_done");
    check("tbl_busy_at_done", 32'(busy), 32'd0);
    check("tbl_words", 32'(words), 32'(NVec));
    check("tbl_err", 32'(err), 32'd0);
    check("tbl_nwrites", 32'(q_addr.size()), 32'(NVec));
    for (int i = 0; i < NVec && i < q_addr.size(); i++) begin
      check($sformatf("tbl_addr%0d", i), q_addr[i], 32'h100 + 32'(4 * i));
      check($sformatf("tbl_data%0d", i), q_data[i], tbl[i].word);
    end
    @(negedge clk);
    check("done_pulse_one", 32'(done), 32'd0);

    // Stall: write held four cycles with imem_ready low for three
    do_start(32'h200);
    imem_ready = 1'b0;
    send(tbl[3], 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("stall_we%0d", k), 32'(imem_we), 32'd1);
      check($sformatf("stall_addr%0d", k), imem_addr, 32'h200);
      check($sformatf("stall_data%0d", k), imem_wdata, 32'h0080006F);
      check($sformatf("stall_rdy%0d", k), 32'(in_ready), 32'd0);
      if (k == 2) begin
        @(posedge clk); #1;
        imem_ready = 1'b1;
      end
    end
    @(negedge clk);
    check("stall_done", 32'(done), 32'd1);
    check("stall_we_after", 32'(imem_we), 32'd0);
    check("stall_words", 32'(words), 32'd1);
    check("stall_nwrites", 32'(q_addr.size()), 32'd1);

    // Illegal fmt writes a NOP and sets err[0] until the next start
    do_start(32'h300);
    v = tbl[0];
    v.fmt = 3'd6;
    send(v, 1'b1);
    wait_done("ill_done");
    check("ill_err", 32'(err), 32'd1);
    check("ill_data", (q_data.size() > 0) ? q_data[0] : 32'hDEADBEEF, 32'h00000013);
    do_start(32'h300);
    check("ill_err_cleared", 32'(err), 32'd0);
    send(tbl[0], 1'b1);
    wait_done("ill_done2");

    // Immediate range: B with odd offset, I with +2048
    do_start(32'h400);
    v = '{3'd3, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd7, 32'h00000363};
    send(v, 1'b1);
    wait_done("rng_b_done");
    check("rng_b_err", 32'(err), 32'(RangeErr));
    check("rng_b_data", (q_data.size() > 0) ? q_data[0] : 32'hDEADBEEF, 32'h00000363);
    do_start(32'h400);
    v = '{3'd1, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd2048, 32'h80000013};
    send(v, 1'b1);
    wait_done("rng_i_done");
    check("rng_i_err", 32'(err), 32'(RangeErr));
    check("rng_i_data", (q_data.size() > 0) ? q_data[0] : 32'hDEADBEEF, 32'h80000013);

    // Address wrap, then reset with a word pending
    do_start(32'hFFFFFFFF);
    send(tbl[1], 1'b0);
    send(tbl[0], 1'b0);
    send(tbl[4], 1'b0);
    imem_ready = 1'b0;
    @(negedge clk);
    check("wrap_nwrites", 32'(q_addr.size()), 32'd2);
    check("wrap_addr0", (q_addr.size() > 0) ? q_addr[0] : 32'hDEADBEEF, 32'hFFFFFFFC);
    check("wrap_addr1", (q_addr.size() > 1) ? q_addr[1] : 32'hDEADBEEF, 32'h00000000);
    check("pend_addr", imem_addr, 32'h4);
    check("pend_we", 32'(imem_we), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_we", 32'(imem_we), 32'd0);
    check("mrst_addr", imem_addr, 32'd0);
    check("mrst_wdata", imem_wdata, 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_words", 32'(words), 32'd0);
    check("mrst_in_ready", 32'(in_ready), 32'd0);
    imem_ready = 1'b1;
    in_valid   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("post_rst_nwrites", 32'(q_addr.size()), 32'd2);
    check("post_rst_we", 32'(imem_we), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
